neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac.sv | 126 ++++++++++++
 tb/tb_neuron_mac.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate for one neuron.
// Accepts (x, w) beats over a valid/ready handshake, adds a programmable
// bias, and delivers a rounded, saturated Q4.4 pre-activation value to
// the downstream sigmoid stage over a second valid/ready handshake.
module neuron_mac #(
  parameter int MAX_TERMS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       bias_load,
  input  logic [7:0] bias_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x_in,
  input  logic [7:0] w_in,
  input  logic       last_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] z_out,
  output logic       sat_out
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  // Beat counter only ever has to reach MAX_TERMS (at most 16).
  localparam logic [4:0] MAX_CNT = 5'(MAX_TERMS);

  state_t             state;
  logic signed [19:0] acc;
  logic [4:0]         count;
  logic [7:0]         bias;

  logic               beat;
  logic signed [15:0] product;
  logic signed [19:0] bias_ext;
  logic signed [19:0] acc_base;
  logic signed [19:0] acc_sum;
  logic               last_beat;
  logic signed [20:0] rounded;
  logic signed [16:0] shifted;
  logic [7:0]         z_sat;
  logic               sat_flag;

  // Input side is open whenever we are out of reset, enabled and not
  // holding a result for the sigmoid stage.
  assign in_ready = rst_n & ena & (state != OUT);
  assign beat     = in_valid & in_ready;

  // Q4.4 * Q4.4 gives a full-precision Q8.8 product.
  assign product  = $signed(x_in) * $signed(w_in);

  // Bias moves from Q4.4 to Q12.8: sign-extend, then four fractional zeros.
  assign bias_ext = {{8{bias[7]}}, bias, 4'b0000};

  // The first beat of a vector starts from the bias instead of the old sum,
  // which is also why a same-edge bias_load only affects the next vector.
  assign acc_base = (state == IDLE) ? bias_ext : acc;
  assign acc_sum  = acc_base + {{4{product[15]}}, product};

  // Running out of terms ends the vector exactly like an explicit last_in.
  assign last_beat = last_in |
                     ((state == IDLE) ? (MAX_CNT == 5'd1) : ((count + 5'd1) == MAX_CNT));

  // Round half up (add half an output LSB) and drop four fraction bits;
  // the extra bit keeps the +8 from wrapping at the top of the range.
  assign rounded = {acc_sum[19], acc_sum} + 21'sd8;
  assign shifted = 17'(rounded >>> 4);

  // Clip the Q12.4 result into the signed 8-bit Q4.4 output range.
  always_comb begin
    z_sat    = shifted[7:0];
    sat_flag = 1'b0;
    if (shifted > 17'sd127) begin
      z_sat    = 8'h7F;
      sat_flag = 1'b1;
    end else if (shifted < -17'sd128) begin
      z_sat    = 8'h80;
      sat_flag = 1'b1;
    end
  end

  // Control FSM plus datapath registers; ena=0 freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      bias      <= '0;
      out_valid <= 1'b0;
      z_out     <= '0;
      sat_out   <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE, ACC: begin
          if (state == IDLE && bias_load) begin
            bias <= bias_in;
          end
          if (beat) begin
            acc   <= acc_sum;
            count <= (state == IDLE) ? 5'd1 : count + 5'd1;
            if (last_beat) begin
              state     <= OUT;
              out_valid <= 1'b1;
              z_out     <= z_sat;
              sat_out   <= sat_flag;
            end else begin
              state <= ACC;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: table-driven directed vectors, hand-written corner-case
// sequences and randomized vectors checked against an arithmetic model.
module tb_neuron_mac;

  typedef logic [15:0][7:0] beats_t;

  typedef struct {
    string      name;
    int         n;
    logic [7:0] bias;
    beats_t     xs;
    beats_t     ws;
    bit         use_last;
    int         hold;
    bit         rand_ena;
    logic [7:0] exp_z;
    bit         exp_sat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       bias_load = 1'b0;
  logic [7:0] bias_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x_in = '0;
  logic [7:0] w_in = '0;
  logic       last_in = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] z_out;
  logic       sat_out;

  int vectors = 0;
  int miscompares = 0;

  neuron_mac #(.MAX_TERMS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .bias_load (bias_load),
    .bias_in   (bias_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .last_in   (last_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_out     (z_out),
    .sat_out   (sat_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact sum of bias and products, round half up, clip.
  function automatic void model(input logic [7:0] b, input int n,
                                input beats_t xs, input beats_t ws,
                                output logic [7:0] z, output bit s);
    int sum, xi, wi, bi, r;
    bi  = int'($signed(b));
    sum = bi * 16;
    for (int i = 0; i < n; i++) begin
      xi  = int'($signed(xs[i]));
      wi  = int'($signed(ws[i]));
      sum = sum + xi * wi;
    end
    r = (sum + 8) >>> 4;
    s = (r > 127) || (r < -128);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    z = 8'(r);
  endfunction

  task automatic set_bias(input logic [7:0] b);
    ena = 1'b1; in_valid = 1'b0; bias_load = 1'b1; bias_in = b;
    @(negedge clk);
    bias_load = 1'b0;
  endtask

  // Called at a negedge with the DUT idle. Feeds n beats, then checks
  // latency, the held result under backpressure and the return to idle.
  task automatic run_vector(input string tag, input int n, input beats_t xs, input beats_t ws,
                            input bit use_last, input bit co_load, input logic [7:0] bias_val,
                            input int hold, input bit rand_ena,
                            input logic [7:0] exp_z, input bit exp_sat);
    int  i, guard, cyc;
    bit  acc_now, hs, done;
    i = 0; guard = 0;
    while (i < n && guard < 2000) begin
      ena       = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = ($urandom_range(0, 4) != 0);
      x_in      = xs[i];
      w_in      = ws[i];
      last_in   = use_last && (i == n - 1);
      bias_load = co_load && (i == 0);
      bias_in   = bias_val;
      if (co_load && i == 0) begin
        ena = 1'b1; in_valid = 1'b1;
      end
      #1;
      acc_now = in_valid && in_ready;
      @(negedge clk);
      if (acc_now) i++;
      guard++;
    end
    bias_load = 1'b0; in_valid = 1'b0; last_in = 1'b0;
    if (i != n) check({tag, " beats_accepted"}, i, n);
    check({tag, " latency_out_valid"}, int'(out_valid), 1);
    check({tag, " z_out"}, int'(z_out), int'(exp_z));
    check({tag, " sat_out"}, int'(sat_out), int'(exp_sat));
    check({tag, " in_ready_in_out"}, int'(in_ready), 0);
    done = 1'b0; cyc = 0;
    while (!done && cyc < 300) begin
      ena       = rand_ena ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = (cyc >= hold) && ($urandom_range(0, 2) == 0);
      in_valid  = $urandom_range(0, 1);
      x_in      = 8'($urandom);
      w_in      = 8'($urandom);
      #1;
      hs = ena && out_ready;
      if (ena) check({tag, " in_ready_blocked"}, int'(in_ready), 0);
      @(negedge clk);
      if (hs) begin
        done = 1'b1;
      end else begin
        check({tag, " held_valid"}, int'(out_valid), 1);
        check({tag, " held_z"}, int'(z_out), int'(exp_z));
      end
      cyc++;
    end
    out_ready = 1'b0; in_valid = 1'b0; ena = 1'b1;
    #1;
    check({tag, " handshake_done"}, int'(done), 1);
    check({tag, " idle_out_valid"}, int'(out_valid), 0);
    check({tag, " idle_in_ready"}, int'(in_ready), 1);
    $display("vec %s: n=%0d z=0x%02h sat=%0d", tag, n, exp_z, exp_sat);
  endtask

  vec_t       tbl [6];
  beats_t     xs, ws;
  logic [7:0] cur_bias;
  logic [7:0] ez;
  bit         es;

  initial begin
    // Table of directed vectors with hand-derived results.
    for (int k = 0; k < 6; k++) begin
      tbl[k].xs = '0; tbl[k].ws = '0; tbl[k].use_last = 1'b1;
      tbl[k].hold = 0; tbl[k].rand_ena = 1'b0; tbl[k].bias = 8'h00; tbl[k].exp_sat = 1'b0;
    end
    tbl[0].name = "single"; tbl[0].n = 1; tbl[0].xs[0] = 8'h10; tbl[0].ws[0] = 8'h10;
    tbl[0].exp_z = 8'h10;
    tbl[1].name = "three_bp"; tbl[1].n = 3; tbl[1].bias = 8'h08; tbl[1].hold = 5;
    tbl[1].xs[0] = 8'h20; tbl[1].ws[0] = 8'h08;
    tbl[1].xs[1] = 8'hF0; tbl[1].ws[1] = 8'h10;
    tbl[1].xs[2] = 8'h18; tbl[1].ws[2] = 8'h20;
    tbl[1].exp_z = 8'h38;
    tbl[2].name = "sat_pos"; tbl[2].n = 4; tbl[2].exp_z = 8'h7F; tbl[2].exp_sat = 1'b1;
    tbl[3].name = "sat_neg"; tbl[3].n = 4; tbl[3].exp_z = 8'h80; tbl[3].exp_sat = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tbl[2].xs[k] = 8'h7F; tbl[2].ws[k] = 8'h7F;
      tbl[3].xs[k] = 8'h80; tbl[3].ws[k] = 8'h7F;
    end
    tbl[4].name = "auto_term"; tbl[4].n = 16; tbl[4].use_last = 1'b0; tbl[4].exp_z = 8'h10;
    for (int k = 0; k < 16; k++) begin
      tbl[4].xs[k] = 8'h01; tbl[4].ws[k] = 8'h10;
    end
    tbl[5] = tbl[1];
    tbl[5].name = "three_freeze"; tbl[5].rand_ena = 1'b1; tbl[5].hold = 2;

    // Reset state.
    rst_n = 1'b0; ena = 1'b1;
    repeat (3) @(negedge clk);
    check("rst out_valid", int'(out_valid), 0);
    check("rst z_out", int'(z_out), 0);
    check("rst sat_out", int'(sat_out), 0);
    check("rst in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst in_ready", int'(in_ready), 1);

    for (int k = 0; k < 6; k++) begin
      set_bias(tbl[k].bias);
      run_vector(tbl[k].name, tbl[k].n, tbl[k].xs, tbl[k].ws, tbl[k].use_last, 1'b0, 8'h00,
                 tbl[k].hold, tbl[k].rand_ena, tbl[k].exp_z, tbl[k].exp_sat);
    end

    // bias_load on the same edge as the first beat: old bias (0) applies,
    // the new bias (1.0) applies to the following vector.
    set_bias(8'h00);
    xs = '0; ws = '0; xs[0] = 8'h10; ws[0] = 8'h10;
    run_vector("coload_old", 1, xs, ws, 1'b1, 1'b1, 8'h10, 0, 1'b0, 8'h10, 1'b0);
    run_vector("coload_new", 1, xs, ws, 1'b1, 1'b0, 8'h00, 0, 1'b0, 8'h20, 1'b0);

    // Reset mid-vector: partial sum and bias are discarded.
    set_bias(8'h30);
    ena = 1'b1; in_valid = 1'b1; x_in = 8'h7F; w_in = 8'h7F; last_in = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    check("midrst in_ready", int'(in_ready), 0);
    @(negedge clk);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst z_out", int'(z_out), 0);
    check("midrst sat_out", int'(sat_out), 0);
    rst_n = 1'b1;
    run_vector("after_rst", 1, xs, ws, 1'b1, 1'b0, 8'h00, 0, 1'b0, 8'h10, 1'b0);

    // Randomized vectors against the model.
    cur_bias = 8'h00;
    for (int v = 0; v < 25; v++) begin
      int  n;
      bit  ul;
      n  = $urandom_range(1, 16);
      ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) begin
        xs[k] = 8'($urandom);
        ws[k] = 8'($urandom);
      end
      if ($urandom_range(0, 1) != 0) begin
        cur_bias = 8'($urandom);
        set_bias(cur_bias);
      end
      model(cur_bias, n, xs, ws, ez, es);
      run_vector($sformatf("rand%0d", v), n, xs, ws, ul, 1'b0, 8'h00,
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ez, es);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
